// File: rtl/chu_gpi_debounce_if.sv
// rtl/chu_gpi_debounce_if.sv - slot bus bundle for the GPI debounce core
// Purpose: groups the cs/read/write/addr/wr_data/rd_data slot bus.
// Ports: none; master modport drives the strobes and write data,
//        slave modport returns combinational rd_data.
interface chu_gpi_debounce_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/chu_gpi_debounce.sv
// rtl/chu_gpi_debounce.sv - synchronised, debounced GPI slot with sticky edge events
// Purpose: two-flop synchroniser and per-bit debounce counter on W raw inputs,
//          sticky rise/fall EVENT flags and a level interrupt.
// Ports: clk   - system clock
//        reset - asynchronous active-high reset
//        bus   - slot bus (cs/read/write/addr/wr_data in, rd_data out)
//        din   - raw asynchronous inputs [W-1:0]
//        irq   - level interrupt, OR of all EVENT bits
module chu_gpi_debounce #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  chu_gpi_debounce_if.slave   bus,
  input  logic [W-1:0]        din,
  output logic                irq
);

  localparam logic [4:0] ADDR_DATA     = 5'h00;
  localparam logic [4:0] ADDR_DEBOUNCE = 5'h01;
  localparam logic [4:0] ADDR_EVENT    = 5'h02;
  localparam logic [4:0] ADDR_RISE_EN  = 5'h03;
  localparam logic [4:0] ADDR_FALL_EN  = 5'h04;

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [W-1:0]     stable;
  logic [CNT_W-1:0] cnt [W];
  logic [CNT_W-1:0] db_reg;
  logic [W-1:0]     event_reg;
  logic [W-1:0]     rise_en;
  logic [W-1:0]     fall_en;

  logic             wr_db;
  logic             wr_event;
  logic             wr_rise;
  logic             wr_fall;
  logic [W-1:0]     upd;
  logic [W-1:0]     new_events;
  logic [W-1:0]     clr_mask;
  logic             unused_wr_bits;

  assign wr_db    = bus.cs && bus.write && (bus.addr == ADDR_DEBOUNCE);
  assign wr_event = bus.cs && bus.write && (bus.addr == ADDR_EVENT);
  assign wr_rise  = bus.cs && bus.write && (bus.addr == ADDR_RISE_EN);
  assign wr_fall  = bus.cs && bus.write && (bus.addr == ADDR_FALL_EN);

  // Bits of wr_data above W / CNT_W are intentionally dropped.
  assign unused_wr_bits = ^bus.wr_data;

  // A bit commits when its mismatch has survived db_reg+1 edges. A DEBOUNCE
  // write restarts every filter, so no bit may commit on that edge.
  always_comb begin
    upd = '0;
    for (int i = 0; i < W; i++) begin
      upd[i] = !wr_db && (sync2[i] != stable[i]) && (cnt[i] == db_reg);
    end
  end

  assign new_events = (upd & sync2 & rise_en) | (upd & ~sync2 & fall_en);
  assign clr_mask   = wr_event ? bus.wr_data[W-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      stable    <= '0;
      db_reg    <= '0;
      event_reg <= '0;
      rise_en   <= '0;
      fall_en   <= '0;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= din;
      sync2 <= sync1;

      if (wr_db)   db_reg  <= bus.wr_data[CNT_W-1:0];
      if (wr_rise) rise_en <= bus.wr_data[W-1:0];
      if (wr_fall) fall_en <= bus.wr_data[W-1:0];

      for (int i = 0; i < W; i++) begin
        if (wr_db || (sync2[i] == stable[i])) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end

      // A fresh event outranks a W1C of the same bit on the same edge.
      event_reg <= (event_reg & ~clr_mask) | new_events;
    end
  end

  assign irq = |event_reg;

  always_comb begin
    bus.rd_data = '0;
    if (bus.cs && bus.read) begin
      case (bus.addr)
        ADDR_DATA:     bus.rd_data[W-1:0]     = stable;
        ADDR_DEBOUNCE: bus.rd_data[CNT_W-1:0] = db_reg;
        ADDR_EVENT:    bus.rd_data[W-1:0]     = event_reg;
        ADDR_RISE_EN:  bus.rd_data[W-1:0]     = rise_en;
        ADDR_FALL_EN:  bus.rd_data[W-1:0]     = fall_en;
        default:       bus.rd_data            = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_chu_gpi_debounce.sv
// tb/tb_chu_gpi_debounce.sv - directed self-checking bench for chu_gpi_debounce
module tb_chu_gpi_debounce;
  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       irq;
  logic [31:0] rv;

  int n_checks;
  int n_pass;

  chu_gpi_debounce_if bus ();

  chu_gpi_debounce #(.W(8), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .din   (din),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
    #1;
    d = bus.rd_data;
    bus.cs = 1'b0; bus.read = 1'b0; bus.addr = '0;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    reset = 1'b1;
    din = '0;
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.addr = '0; bus.wr_data = '0;
    edges(3);
    reset = 1'b0;
    edges(1);

    // reset state
    bus_read(5'h00, rv); check("rst_data", rv, 32'h0);
    bus_read(5'h01, rv); check("rst_db", rv, 32'h0);
    bus_read(5'h02, rv); check("rst_event", rv, 32'h0);
    bus_read(5'h03, rv); check("rst_rise_en", rv, 32'h0);
    bus_read(5'h04, rv); check("rst_fall_en", rv, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rd_idle", bus.rd_data, 32'h0);

    // 1: db=0, three-edge latency, no irq
    edges(10);
    din = 8'h01;
    edges(2);
    bus_read(5'h00, rv); check("t1_data_e2", rv, 32'h00);
    edges(1);
    bus_read(5'h00, rv); check("t1_data_e3", rv, 32'h01);
    check("t1_irq", {31'b0, irq}, 32'h0);

    // 2: db=4, glitch rejected, then rise after 7 edges
    bus_write(5'h01, 32'd4);
    bus_write(5'h03, 32'h01);
    din = 8'h00;
    edges(10);
    bus_read(5'h00, rv); check("t2_data_low", rv, 32'h00);
    bus_read(5'h02, rv); check("t2_event_fall", rv, 32'h00);
    din = 8'h01;
    edges(3);
    din = 8'h00;
    edges(10);
    bus_read(5'h00, rv); check("t2_glitch_data", rv, 32'h00);
    bus_read(5'h02, rv); check("t2_glitch_event", rv, 32'h00);
    check("t2_glitch_irq", {31'b0, irq}, 32'h0);
    din = 8'h01;
    edges(6);
    bus_read(5'h00, rv); check("t2_data_e6", rv, 32'h00);
    edges(1);
    bus_read(5'h00, rv); check("t2_data_e7", rv, 32'h01);
    bus_read(5'h02, rv); check("t2_event", rv, 32'h01);
    check("t2_irq", {31'b0, irq}, 32'h1);

    // 3: W1C clears only the written bits
    bus_write(5'h01, 32'd0);
    bus_write(5'h03, 32'h03);
    din = 8'h03;
    edges(3);
    bus_read(5'h02, rv); check("t3_event_both", rv, 32'h03);
    bus_write(5'h02, 32'h01);
    bus_read(5'h02, rv); check("t3_event_clr0", rv, 32'h02);
    check("t3_irq_kept", {31'b0, irq}, 32'h1);
    bus_write(5'h02, 32'h02);
    bus_read(5'h02, rv); check("t3_event_clr1", rv, 32'h00);
    check("t3_irq_gone", {31'b0, irq}, 32'h0);

    // 4: fall event wins over a same-edge W1C
    bus_write(5'h04, 32'h04);
    din = 8'h07;
    edges(4);
    bus_read(5'h00, rv); check("t4_data_hi", rv, 32'h07);
    bus_read(5'h02, rv); check("t4_no_rise", rv, 32'h00);
    din = 8'h03;
    edges(2);
    bus_read(5'h02, rv); check("t4_event_pre", rv, 32'h00);
    bus_write(5'h02, 32'h04);
    bus_read(5'h00, rv); check("t4_data_lo", rv, 32'h03);
    bus_read(5'h02, rv); check("t4_set_wins", rv, 32'h04);
    check("t4_irq", {31'b0, irq}, 32'h1);
    bus_write(5'h02, 32'h04);
    bus_read(5'h02, rv); check("t4_cleared", rv, 32'h00);

    // 5: DEBOUNCE rewrite mid-count restarts the filter
    bus_write(5'h01, 32'd100);
    din = 8'h02;
    edges(52);
    bus_write(5'h01, 32'd100);
    edges(100);
    bus_read(5'h00, rv); check("t5_data_e100", rv, 32'h03);
    edges(1);
    bus_read(5'h00, rv); check("t5_data_e101", rv, 32'h02);
    bus_read(5'h02, rv); check("t5_event", rv, 32'h00);

    // 6: reset mid-count
    bus_write(5'h03, 32'hFF);
    din = 8'hFF;
    edges(20);
    reset = 1'b1;
    #1;
    bus_read(5'h00, rv); check("t6_rst_data", rv, 32'h0);
    bus_read(5'h01, rv); check("t6_rst_db", rv, 32'h0);
    bus_read(5'h03, rv); check("t6_rst_rise", rv, 32'h0);
    bus_read(5'h04, rv); check("t6_rst_fall", rv, 32'h0);
    check("t6_rst_irq", {31'b0, irq}, 32'h0);
    edges(1);
    reset = 1'b0;
    edges(2);
    bus_read(5'h00, rv); check("t6_data_e2", rv, 32'h00);
    edges(1);
    bus_read(5'h00, rv); check("t6_data_e3", rv, 32'hFF);
    bus_read(5'h02, rv); check("t6_event", rv, 32'h00);
    check("t6_irq", {31'b0, irq}, 32'h0);
    bus_read(5'h07, rv); check("t6_unmapped", rv, 32'h0);

    // widths: upper write bits dropped, reads zero-extended
    bus_write(5'h01, 32'hFFFF_1234);
    bus_read(5'h01, rv); check("w_db_trunc", rv, 32'h0000_1234);
    bus_write(5'h03, 32'h0000_01A5);
    bus_read(5'h03, rv); check("w_rise_trunc", rv, 32'h0000_00A5);
    bus_write(5'h07, 32'hFFFF_FFFF);
    bus_read(5'h03, rv); check("w_unmapped_wr", rv, 32'h0000_00A5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
